// File: rtl/multdiv_if.sv
// Operand, start and result signals shared between the execute stage and the
// iterative multiply/divide unit.
interface multdiv_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply/divide: one shared unsigned add/subtract
// datapath runs 32 iterations on operand magnitudes, then applies sign correction.
module multdiv_unit (
  input  logic     clock,
  input  logic     reset_n,
  multdiv_if.slave mdu
);

  // state | meaning
  // IDLE  | waiting for a ctrl_MULT / ctrl_DIV start pulse
  // RUN   | one shift/add (mult) or shift/subtract (div) step per edge
  // DONE  | sign-correct, publish result and exception, pulse ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic        r_is_mult;
  logic        r_neg;
  logic        r_dbz;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [4:0]  r_count;
  logic [31:0] r_result;
  logic        r_exception;
  logic        r_rdy;

  logic        w_start;
  logic        w_start_mult;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_rem_sh;
  logic [33:0] w_op1;
  logic [33:0] w_op2;
  logic [33:0] w_sum;
  logic        w_borrow;
  logic [31:0] w_rem_next;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod_signed;
  logic        w_mult_ovf;
  logic [31:0] w_quot_signed;
  logic        w_div_ovf;

  assign w_start      = mdu.ctrl_MULT | mdu.ctrl_DIV;
  assign w_start_mult = mdu.ctrl_MULT;
  assign w_abs_a      = mdu.data_operandA[31] ? (32'd0 - mdu.data_operandA) : mdu.data_operandA;
  assign w_abs_b      = mdu.data_operandB[31] ? (32'd0 - mdu.data_operandB) : mdu.data_operandB;

  // Shared adder: mult adds |A| into the upper half, div subtracts |B| from
  // the shifted partial remainder (two's complement with carry-in).
  assign w_rem_sh = {r_acc[63:32], r_a[31]};
  assign w_op1    = r_is_mult ? {2'b00, r_acc[63:32]} : {1'b0, w_rem_sh};
  assign w_op2    = r_is_mult ? (r_b[0] ? {2'b00, r_a} : 34'd0) : ~{2'b00, r_b};
  assign w_sum    = w_op1 + w_op2 + {33'd0, ~r_is_mult};

  assign w_borrow   = w_sum[33];
  assign w_rem_next = w_borrow ? w_rem_sh[31:0] : w_sum[31:0];
  assign w_acc_next = r_is_mult ? {w_sum[32:0], r_acc[31:1]}
                                : {w_rem_next, r_acc[30:0], ~w_borrow};

  assign w_prod_signed = r_neg ? (64'd0 - r_acc) : r_acc;
  assign w_mult_ovf    = ~((&w_prod_signed[63:31]) | ~(|w_prod_signed[63:31]));
  assign w_quot_signed = r_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_div_ovf     = ~r_neg & r_acc[31];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (!w_start_mult && (mdu.data_operandB == 32'd0)) begin
            w_state_next = DONE;
          end else begin
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        if (r_count == 5'd31) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_is_mult   <= 1'b0;
      r_neg       <= 1'b0;
      r_dbz       <= 1'b0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_acc       <= 64'd0;
      r_count     <= 5'd0;
      r_result    <= 32'd0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_is_mult <= w_start_mult;
            r_neg     <= mdu.data_operandA[31] ^ mdu.data_operandB[31];
            r_dbz     <= ~w_start_mult & (mdu.data_operandB == 32'd0);
            r_a       <= w_abs_a;
            r_b       <= w_abs_b;
            r_acc     <= 64'd0;
            r_count   <= 5'd0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + 5'd1;
          if (r_is_mult) begin
            r_b <= {1'b0, r_b[31:1]};
          end else begin
            r_a <= {r_a[30:0], 1'b0};
          end
        end
        DONE: begin
          r_rdy <= 1'b1;
          if (r_dbz) begin
            r_result    <= 32'd0;
            r_exception <= 1'b1;
          end else if (r_is_mult) begin
            r_result    <= w_prod_signed[31:0];
            r_exception <= w_mult_ovf;
          end else begin
            // Only 0x80000000 / -1 overflows; its quotient is already 0x80000000.
            r_result    <= w_quot_signed;
            r_exception <= w_div_ovf;
          end
        end
        default: begin
          r_count <= 5'd0;
        end
      endcase
    end
  end

  assign mdu.data_result    = r_result;
  assign mdu.data_exception = r_exception;
  assign mdu.data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized and directed bench for multdiv_unit: expected results come from
// plain signed arithmetic and are matched against ready pulses by a monitor.
module tb_multdiv_unit;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   n_vec;
  int   n_bad;
  logic [31:0] last_res;
  logic        last_exc;
  exp_t sb[$];

  multdiv_if bus();

  multdiv_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mdu     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                 input int now);
    exp_t   e;
    longint p;
    int     qa;
    int     qb;
    e.cyc = now + 34;
    if (m) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
      e.cyc = now + 2;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      qa    = $signed(a);
      qb    = $signed(b);
      e.res = 32'(qa / qb);
      e.exc = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      last_res = 32'd0;
      last_exc = 1'b0;
    end else if (bus.data_resultRDY) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rdy: got rdy with result=%h exc=%b at cycle %0d, required no rdy",
                 bus.data_result, bus.data_exception, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.data_result !== e.res || bus.data_exception !== e.exc || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL result: got res=%h exc=%b cycle=%0d, required res=%h exc=%b cycle=%0d",
                   bus.data_result, bus.data_exception, cyc, e.res, e.exc, e.cyc);
        end
      end
      last_res = bus.data_result;
      last_exc = bus.data_exception;
    end else begin
      n_vec++;
      if (bus.data_result !== last_res || bus.data_exception !== last_exc) begin
        n_bad++;
        $display("FAIL hold: got res=%h exc=%b without rdy, required res=%h exc=%b",
                 bus.data_result, bus.data_exception, last_res, last_exc);
      end
    end
  end

  task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    sb.push_back(model(m, a, b, cyc));
    @(posedge clock); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL timeout: %0d results still pending after %0d cycles, required 0",
               sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (bus.data_result !== 32'd0 || bus.data_exception !== 1'b0 || bus.data_resultRDY !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got res=%h exc=%b rdy=%b, required all 0",
               name, bus.data_result, bus.data_exception, bus.data_resultRDY);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 60));
      4:       return 32'(0 - $urandom_range(1, 60));
      5:       return 32'($urandom_range(0, 32'h0001_FFFF));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_vec             = 0;
    n_bad             = 0;
    last_res          = 32'd0;
    last_exc          = 1'b0;
    reset_n           = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    #23;
    check_zero("reset_state");
    @(posedge clock); #1;
    reset_n = 1'b1;

    start(1, 0, 32'd7, 32'hFFFF_FFFA);
    wait_drain(60);
    start(1, 0, 32'h0001_0000, 32'h0001_0000);
    wait_drain(60);
    start(1, 0, 32'h8000_0000, 32'd1);
    wait_drain(60);
    start(0, 1, 32'hFFFF_FFF9, 32'd2);
    wait_drain(60);
    start(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_drain(60);

    // Divide-by-zero followed by a start in its ready cycle.
    start(0, 1, 32'd5, 32'd0);
    start(1, 0, 32'd3, 32'd4);
    wait_drain(60);

    // Both starts together, then stray starts while busy.
    start(1, 1, 32'hFFFF_FFFD, 32'd9);
    repeat (5) @(posedge clock);
    #1;
    bus.ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    bus.ctrl_DIV  = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV  = 1'b1;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    wait_drain(60);
    repeat (40) @(posedge clock);

    // Reset during iteration 10.
    start(1, 0, 32'h1234_5678, 32'h0000_0003);
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_zero("reset_midop");
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (45) @(posedge clock);
    start(0, 1, 32'd100, 32'd7);
    wait_drain(60);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      bit          m;
      a = pick();
      b = pick();
      m = ($urandom_range(0, 1) == 1);
      start(m, !m, a, b);
      wait_drain(60);
    end

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
